// File: rtl/clone_detect.sv
`default_nettype none
// ============================================================================
// clone_detect : power-on famiclone detector.
// Grounds CIRAM /CE and /A13, then classifies the console from PPU /A13 reads.
// Revision: 1.0
// ============================================================================
module clone_detect #(
   parameter int unsigned INIT_CYCLES    = 15,
   parameter int unsigned SAMPLE_LO      = 3,
   parameter int unsigned SAMPLE_HI      = 3,
   parameter int unsigned MISMATCH_MIN   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic       m2,
   input  logic       rst_n,
   input  logic       rd_event,
   input  logic       rd_a13,
   input  logic       rd_not_a13,
   input  logic       rescan,
   output logic       ground_en,
   output logic       new_dendy,
   output logic       detect_done,
   output logic [7:0] mismatch_cnt
);

   localparam logic [15:0] INIT_LOAD = 16'(INIT_CYCLES);
   localparam logic [7:0]  LO_MAX    = 8'(SAMPLE_LO);
   localparam logic [7:0]  HI_MAX    = 8'(SAMPLE_HI);
   localparam logic [7:0]  MM_MIN    = 8'(MISMATCH_MIN);
   localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_OBSERVE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] init_cnt;
   logic [7:0]  lo_cnt;
   logic [7:0]  hi_cnt;
   logic [31:0] timer;

   logic        window_open;
   logic        mismatch;
   logic [7:0]  mm_next;
   logic [7:0]  lo_next;
   logic [7:0]  hi_next;
   logic [31:0] timer_next;
   logic        window_close;
   logic        timeout_hit;

   // Next-window values include the current read, so the closing read counts.
   always_comb begin
      window_open  = (lo_cnt < LO_MAX) && (hi_cnt < HI_MAX);
      mismatch     = rd_event && window_open && (rd_not_a13 == rd_a13);
      mm_next      = (mismatch && (mismatch_cnt != 8'hFF)) ? mismatch_cnt + 8'd1 : mismatch_cnt;
      lo_next      = (rd_event && !rd_a13 && (lo_cnt < LO_MAX)) ? lo_cnt + 8'd1 : lo_cnt;
      hi_next      = (rd_event &&  rd_a13 && (hi_cnt < HI_MAX)) ? hi_cnt + 8'd1 : hi_cnt;
      window_close = (lo_next == LO_MAX) || (hi_next == HI_MAX) || (mm_next >= MM_MIN);
      timer_next   = timer + 32'd1;
      timeout_hit  = (TO_LIMIT != 32'd0) && (timer_next == TO_LIMIT);
   end

   always_ff @(posedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_INIT;
         init_cnt     <= INIT_LOAD;
         lo_cnt       <= 8'd0;
         hi_cnt       <= 8'd0;
         timer        <= 32'd0;
         ground_en    <= 1'b1;
         new_dendy    <= 1'b0;
         detect_done  <= 1'b0;
         mismatch_cnt <= 8'd0;
      end else if (rescan) begin
         if (state == ST_DONE) begin
            new_dendy <= 1'b0;
         end
         state        <= ST_INIT;
         init_cnt     <= INIT_LOAD;
         lo_cnt       <= 8'd0;
         hi_cnt       <= 8'd0;
         timer        <= 32'd0;
         ground_en    <= 1'b1;
         detect_done  <= 1'b0;
         mismatch_cnt <= 8'd0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt - 16'd1;
               if (init_cnt == 16'd1) begin
                  state     <= ST_OBSERVE;
                  ground_en <= 1'b0;
               end
            end
            ST_OBSERVE: begin
               timer        <= timer_next;
               mismatch_cnt <= mm_next;
               lo_cnt       <= lo_next;
               hi_cnt       <= hi_next;
               // A closing read takes precedence over a coincident timeout.
               if (window_close) begin
                  state       <= ST_DONE;
                  detect_done <= 1'b1;
                  new_dendy   <= (mm_next >= MM_MIN);
               end else if (timeout_hit) begin
                  state       <= ST_DONE;
                  detect_done <= 1'b1;
                  new_dendy   <= 1'b0;
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
